// File: rtl/booth_mul.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// Processes one recode/shift step per clock and finishes after WIDTH steps.
// It uses the same start/valid/busy handshake as the divider. The block only
// responds when muordi=0.
module booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 muordi,
  input  logic [WIDTH-1:0]     opera1,
  input  logic [WIDTH-1:0]     opera2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 valid,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  // The accumulator and multiplicand are one bit wider than an operand.
  // This keeps A-M from overflowing when opera1 is the most negative value.
  logic signed [WIDTH:0]     a_q, a_d;
  logic signed [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]          q_q, q_d;
  logic                      q1_q, q1_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2*WIDTH-1:0]        result_q, result_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic signed [WIDTH:0]     sum;

  // Booth recode of {Q[0],Q_1}: 01 adds M, 10 subtracts M, and 00/11 leave A unchanged.
  function automatic logic signed [WIDTH:0] booth_add(
    input logic signed [WIDTH:0] acc,
    input logic signed [WIDTH:0] mcand,
    input logic [1:0]            code
  );
    case (code)
      2'b01:   booth_add = acc + mcand;
      2'b10:   booth_add = acc - mcand;
      default: booth_add = acc;
    endcase
  endfunction

  // Next-state logic: launch in IDLE/DONE, and one Booth step per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    q_d      = q_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    sum      = a_q;
    case (state_q)
      RUN: begin
        sum   = booth_add(a_q, m_q, {q_q[0], q1_q});
        // Arithmetic right shift of {A,Q,Q_1}. The sign bit of A is replicated.
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = {a_d[WIDTH-1:0], q_d};
          valid_d  = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        // In IDLE or DONE, a multiply start launches a new operation.
        // The previous result stays visible until the new product is written.
        if (start && !muordi) begin
          state_d = RUN;
          m_d     = {opera1[WIDTH-1], opera1};
          q_d     = opera2;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  // State register. Reset clears everything, including a half-finished product.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_booth_mul.sv
// Scoreboard bench for booth_mul. The driver pushes the arithmetic product
// onto a queue. The monitor pops and compares on every rising edge of valid.
module tb_booth_mul;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           muordi;
  logic [W-1:0]   opera1;
  logic [W-1:0]   opera2;
  logic [2*W-1:0] result;
  logic           valid;
  logic           busy;

  int             errors = 0;
  int             checks = 0;
  logic [63:0]    exp_q[$];
  logic           valid_prev = 1'b0;

  booth_mul #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .muordi (muordi),
    .opera1 (opera1),
    .opera2 (opera2),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Reference model: the exact signed product, computed in 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every new product must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid === 1'b1 && valid_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h with no operation outstanding", result);
      end else begin
        check("product", result, exp_q.pop_front());
      end
    end
    valid_prev <= valid;
  end

  // Launch one multiply, then wait for it. This checks the accept edge, the
  // latency, the busy length, and that result holds its old value meanwhile.
  // If repulse > 0, a stray start with junk operands is issued on that cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int repulse, input string name);
    int          n;
    int          bcnt;
    logic        held;
    logic [63:0] old;
    @(negedge clock);
    old    = result;
    opera1 = a;
    opera2 = b;
    muordi = 1'b0;
    start  = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    @(negedge clock);
    start  = 1'b0;
    check({name, "_accept_valid"}, 64'(valid), 64'd0);
    check({name, "_accept_busy"}, 64'(busy), 64'd1);
    n    = 0;
    bcnt = 1;
    held = 1'b1;
    while (valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
      if (n == repulse) begin
        start  = 1'b1;
        opera1 = $urandom;
        opera2 = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1) bcnt++;
      if (valid !== 1'b1 && result !== old) held = 1'b0;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'd32);
    check({name, "_busy_cycles"}, 64'(bcnt), 64'd32);
    check({name, "_result_held"}, 64'(held), 64'd1);
  endtask

  initial begin
    int          bad;
    logic [63:0] old;
    reset  = 1'b1;
    start  = 1'b0;
    muordi = 1'b0;
    opera1 = '0;
    opera2 = '0;
    repeat (3) @(negedge clock);
    check("reset_result", result, 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // A start with muordi=1 belongs to the divider, so this block must not react.
    @(negedge clock);
    muordi = 1'b1;
    opera1 = 32'd9;
    opera2 = 32'd4;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    check("divsel_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    check("divsel_valid", 64'(valid), 64'd0);
    check("divsel_result", result, 64'd0);
    muordi = 1'b0;

    // Basic product. It must then stay valid and stable for 200 cycles.
    run_op(32'd3, -32'sd5, -1, "basic");
    check("basic_value", result, 64'hFFFF_FFFF_FFFF_FFF1);
    old = result;
    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (valid !== 1'b1 || result !== old) bad++;
    end
    check("done_hold", 64'(bad), 64'd0);

    // Extreme operands.
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, -1, "maxmax");
    check("maxmax_value", result, 64'h3FFFFFFF00000001);
    run_op(32'h80000000, 32'h80000000, -1, "minmin");
    check("minmin_value", result, 64'h4000000000000000);
    run_op(32'h80000000, 32'h7FFFFFFF, -1, "minmax");
    check("minmax_value", result, 64'hC000000080000000);

    // Trivial operands.
    run_op(32'd0, 32'h12345678, -1, "zero");
    check("zero_value", result, 64'd0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, -1, "negone");
    check("negone_value", result, 64'd1);
    run_op(32'h12121212, 32'd1, -1, "one");
    check("one_value", result, 64'h0000000012121212);

    // A stray start during RUN must not disturb the operation in flight.
    run_op(32'd11, 32'd13, 10, "repulse");
    check("repulse_value", result, 64'd143);

    // Reset in mid-operation aborts it. No result may be exposed afterwards.
    @(negedge clock);
    opera1 = 32'd100;
    opera2 = 32'd200;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_result", result, 64'd0);
    repeat (40) @(negedge clock);
    check("abort_no_valid", 64'(valid), 64'd0);
    run_op(32'd7, -32'sd9, -1, "after_abort");
    check("after_abort_value", result, 64'hFFFF_FFFF_FFFF_FFC1);

    // Back-to-back: a new start while valid is high clears valid.
    // The old result stays visible until the new product is written.
    run_op(32'd4, 32'd5, -1, "b2b_first");
    check("b2b_first_value", result, 64'd20);
    run_op(32'd6, -32'sd7, -1, "b2b_second");
    check("b2b_second_value", result, 64'hFFFF_FFFF_FFFF_FFD6);

    // Randomised operands, checked only by the scoreboard.
    for (int i = 0; i < 24; i++) begin
      run_op(32'($urandom), 32'($urandom), -1, "rand");
    end

    repeat (2) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
